// File: rtl/ro_pkg.sv
// Shared definitions for the readout event FIFO: default widths, the event word
// layout and the channel-id width helper.
package ro_pkg;

  localparam int DEF_NCH    = 2;
  localparam int DEF_TS_W   = 10;
  localparam int DEF_DROP_W = 8;

  // Channel-id width; a single-channel build still carries a 1-bit id.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CH_W = clog2_min1(DEF_NCH);

  // Event word for the default I/Q configuration, packed MSB-first as {chan_id, pol, ts}.
  typedef struct packed {
    logic [DEF_CH_W-1:0] chan_id;
    logic                pol;
    logic [DEF_TS_W-1:0] ts;
  } ro_event_t;

endpackage

// File: rtl/ro_sync_fifo.sv
// Synchronous FIFO with a registered head word: a word pushed into an empty FIFO
// is presented on rd_data/rd_valid one cycle after the push edge.
module ro_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_master,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] mem_cnt;
  logic             do_push;
  logic             do_pop;
  logic             load;

  // level counts the storage array plus the head register, so capacity is DEPTH.
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & rd_valid;
  assign mem_cnt = level - LVL_W'(rd_valid);
  assign load    = (mem_cnt != '0) & (~rd_valid | do_pop);

  // NOTE: storage has no reset; rd_valid/level guard every read, so clearing
  // the array would only cost reset fan-out.
  always_ff @(posedge clk_master) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(do_push);
      rd_ptr <= rd_ptr + PTR_W'(load);
      level  <= level + LVL_W'(do_push) - LVL_W'(do_pop);
      if (load) begin
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
      end else if (do_pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ro_event_fifo_cell.sv
// Multi-channel comparator readout: detects phi1b sample strobes, tags captured
// events with {channel, polarity, timestamp} and queues them round-robin.
module ro_event_fifo_cell
  import ro_pkg::*;
#(
  parameter  int NCH    = DEF_NCH,
  parameter  int DEPTH  = 8,
  parameter  int TS_W   = DEF_TS_W,
  parameter  int DROP_W = DEF_DROP_W,
  localparam int CH_W   = clog2_min1(NCH),
  localparam int LVL_W  = $clog2(DEPTH) + 1,
  localparam int EV_W   = CH_W + 1 + TS_W
) (
  input  logic              clk_master,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    comp_high,
  input  logic [NCH-1:0]    phi1b_dig,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EV_W-1:0]   out_data,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overflow
);

  localparam int SUM_W = DROP_W + CH_W + 1;
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

  typedef struct packed {
    logic [CH_W-1:0] chan_id;
    logic            pol;
    logic [TS_W-1:0] ts;
  } event_t;

  logic [TS_W-1:0]   ts;
  logic [NCH-1:0]    phi1b_d;
  logic [NCH-1:0]    pol_ph;
  logic [NCH-1:0]    pend;
  logic [NCH-1:0]    pend_pol;
  logic [TS_W-1:0]   pend_ts [NCH];
  logic [CH_W-1:0]   rr_ptr;

  logic [NCH-1:0]    strb;
  logic [NCH-1:0]    cap;
  logic [NCH-1:0]    drop;
  logic [NCH-1:0]    gnt_oh;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   rr_next;
  logic [SUM_W-1:0]  drop_sum;
  logic [DROP_W-1:0] drop_next;
  event_t            push_word;
  logic              fifo_full;
  logic              fifo_empty;

  function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NCH) sum = sum - NCH;
    return CH_W'(sum);
  endfunction

  assign strb = phi1b_d & ~phi1b_dig;
  assign cap  = strb & comp_high & {NCH{en}};

  // NOTE: every output of this block gets a default first, so no path through
  // the loop can leave a value held and infer a latch.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    if (!fifo_full) begin
      for (int i = 0; i < NCH; i++) begin
        if (!gnt_vld && pend[ch_add(rr_ptr, i)]) begin
          gnt_vld = 1'b1;
          gnt_ch  = ch_add(rr_ptr, i);
        end
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int c = 0; c < NCH; c++) begin
      gnt_oh[c] = gnt_vld && (gnt_ch == CH_W'(c));
    end
  end

  assign rr_next = ch_add(gnt_ch, 1);
  // A channel granted this cycle frees its slot, so a simultaneous capture is kept.
  assign drop = cap & pend & ~gnt_oh;

  always_comb begin
    drop_sum  = SUM_W'(drop_cnt) + SUM_W'($countones(drop));
    drop_next = (drop_sum > DROP_MAX) ? '1 : drop_sum[DROP_W-1:0];
  end

  always_comb begin
    push_word = '{chan_id: gnt_ch, pol: pend_pol[gnt_ch], ts: pend_ts[gnt_ch]};
  end

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      ts       <= '0;
      phi1b_d  <= '1;
      pol_ph   <= '0;
      pend     <= '0;
      pend_pol <= '0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
      for (int c = 0; c < NCH; c++) pend_ts[c] <= '0;
    end else begin
      ts       <= ts + TS_W'(1);
      phi1b_d  <= phi1b_dig;
      pol_ph   <= pol_ph ^ strb;
      drop_cnt <= drop_next;
      overflow <= overflow | (|drop);
      if (gnt_vld) rr_ptr <= rr_next;
      for (int c = 0; c < NCH; c++) begin
        if (cap[c] && !drop[c]) begin
          pend[c]     <= 1'b1;
          pend_pol[c] <= pol_ph[c];
          pend_ts[c]  <= ts;
        end else if (gnt_oh[c]) begin
          pend[c] <= 1'b0;
        end
      end
    end
  end

  ro_sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_master (clk_master),
    .rst        (rst),
    .push       (gnt_vld),
    .push_data  (push_word),
    .pop        (out_ready),
    .rd_data    (out_data),
    .rd_valid   (out_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  empty_means_idle: assert property (@(posedge clk_master) disable iff (rst)
    fifo_empty |-> !out_valid);

endmodule
